// File: rtl/switch_conditioner.sv
// switch_conditioner: per-channel synchroniser, cycle-count debounce, edge
// detection and toggle, with a runtime-selected conditioned output.
module switch_conditioner_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_WIDTH     = 5
) (
  input  logic clock,
  input  logic isReset,
  input  logic raw,
  input  logic clr,
  output logic stable,
  output logic press,
  output logic rel,
  output logic tog
);
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES-1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [COUNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                   sync, accept;

  assign sync = sync_q[SYNC_STAGES-1];

  // Any cycle where sync agrees with stable restarts the count.
  always_comb begin
    cnt_nxt = '0;
    accept  = 1'b0;
    if (sync != stable) begin
      if (cnt == LAST) accept = 1'b1;
      else             cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge isReset) begin
    if (isReset) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      tog    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt    <= cnt_nxt;
      press  <= accept & sync;
      rel    <= accept & ~sync;
      if (accept) stable <= sync;
      // Clear takes priority over a press landing on the same edge.
      if (clr)                 tog <= 1'b0;
      else if (accept && sync) tog <= ~tog;
    end
  end
endmodule

module switch_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_WIDTH     = $clog2(DEBOUNCE_CYCLES+1)
) (
  input  logic                clock,
  input  logic                isReset,
  input  logic [CHANNELS-1:0] switch,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] clearToggle,
  output logic [CHANNELS-1:0] switchOut,
  output logic [CHANNELS-1:0] stable,
  output logic [CHANNELS-1:0] pressPulse,
  output logic [CHANNELS-1:0] releasePulse,
  output logic                anyPress
);
  logic [CHANNELS-1:0] tog;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    switch_conditioner_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .COUNT_WIDTH    (COUNT_WIDTH)
    ) u_lane (
      .clock  (clock),
      .isReset(isReset),
      .raw    (switch[g]),
      .clr    (clearToggle[g]),
      .stable (stable[g]),
      .press  (pressPulse[g]),
      .rel    (releasePulse[g]),
      .tog    (tog[g])
    );
  end

  always_comb begin
    switchOut = stable;
    case (mode)
      2'd0:    switchOut = stable;
      2'd1:    switchOut = pressPulse;
      2'd2:    switchOut = tog;
      default: switchOut = ~stable;
    endcase
  end

  assign anyPress = |pressPulse;
endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: hand-computed vector table, directed corner
// sequences and random stimulus against a sample-window reference model.
module tb_switch_conditioner;
  localparam int CH = 2, S = 2, D = 4;

  logic          clock = 1'b0, isReset = 1'b1;
  logic [CH-1:0] sw = '0, clr = '0;
  logic [1:0]    mode = 2'd0;
  logic [CH-1:0] switchOut, stable, pressPulse, releasePulse;
  logic          anyPress;
  int            checks = 0, errors = 0;

  always #5 clock = ~clock;

  switch_conditioner #(.CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .isReset(isReset), .switch(sw), .mode(mode),
    .clearToggle(clr), .switchOut(switchOut), .stable(stable),
    .pressPulse(pressPulse), .releasePulse(releasePulse), .anyPress(anyPress)
  );

  // Model: the debounce at step n sees the raw sample taken S steps earlier;
  // a change is accepted when the last D such samples all differ from stable.
  logic [CH-1:0] raw_log [0:8191];
  int            n;
  logic [CH-1:0] m_stable, m_press, m_rel, m_tog;

  function automatic logic sync_at(input int m, input int c);
    return (m >= S) ? raw_log[m-S][c] : 1'b0;
  endfunction

  task automatic model_reset();
    n = 0; m_stable = '0; m_press = '0; m_rel = '0; m_tog = '0;
  endtask

  task automatic model_step(input logic [CH-1:0] s, input logic [CH-1:0] c);
    logic acc;
    raw_log[n] = s;
    for (int ch = 0; ch < CH; ch++) begin
      acc = 1'b1;
      for (int j = 0; j < D; j++)
        if (sync_at(n-j, ch) == m_stable[ch]) acc = 1'b0;
      m_press[ch] = acc & ~m_stable[ch];
      m_rel[ch]   = acc & m_stable[ch];
      if (acc) m_stable[ch] = ~m_stable[ch];
      if (c[ch])            m_tog[ch] = 1'b0;
      else if (m_press[ch]) m_tog[ch] = ~m_tog[ch];
    end
    n++;
  endtask

  function automatic logic [CH-1:0] m_out(input logic [1:0] md);
    case (md)
      2'd0:    return m_stable;
      2'd1:    return m_press;
      2'd2:    return m_tog;
      default: return ~m_stable;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model_stable", 32'(stable), 32'(m_stable));
    chk("model_press", 32'(pressPulse), 32'(m_press));
    chk("model_release", 32'(releasePulse), 32'(m_rel));
    chk("model_out", 32'(switchOut), 32'(m_out(mode)));
    chk("model_any", 32'(anyPress), 32'(|m_press));
  endtask

  // Called at a falling edge: drive, take one rising edge, compare at the next fall.
  task automatic cyc(input logic [CH-1:0] s, input logic [1:0] md, input logic [CH-1:0] c);
    sw = s; mode = md; clr = c;
    @(posedge clock);
    model_step(s, c);
    @(negedge clock);
    cmp_model();
  endtask

  typedef struct {
    logic [1:0] sw, md, st, pr, rl, out;
    logic       any;
  } vec_t;
  vec_t tbl [14];

  int pcnt, rcnt;
  logic [CH-1:0] rs, rc;
  logic [1:0]    rm;

  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = '{2'b01, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    tbl[5] = '{2'b01, 2'd0, 2'b01, 2'b01, 2'b00, 2'b01, 1'b1};
    tbl[6] = '{2'b01, 2'd3, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0};
    for (int i = 7; i < 12; i++) tbl[i] = '{2'b00, 2'd0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0};
    tbl[12] = '{2'b00, 2'd0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
    tbl[13] = '{2'b00, 2'd3, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0};

    // Reset state
    #3;
    chk("rst_stable", 32'(stable), 0);
    chk("rst_press", 32'(pressPulse), 0);
    chk("rst_release", 32'(releasePulse), 0);
    chk("rst_out_mode0", 32'(switchOut), 0);
    chk("rst_any", 32'(anyPress), 0);
    mode = 2'd3; #1;
    chk("rst_out_mode3", 32'(switchOut), 32'h3);
    @(negedge clock);
    isReset = 1'b0; mode = 2'd0; model_reset();

    // Clean press and release on channel 0 from the vector table
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].sw, tbl[i].md, '0);
      chk($sformatf("tbl%0d_stable", i), 32'(stable), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_press", i), 32'(pressPulse), 32'(tbl[i].pr));
      chk($sformatf("tbl%0d_release", i), 32'(releasePulse), 32'(tbl[i].rl));
      chk($sformatf("tbl%0d_out", i), 32'(switchOut), 32'(tbl[i].out));
      chk($sformatf("tbl%0d_any", i), 32'(anyPress), 32'(tbl[i].any));
    end

    // Bounce: 3 high, 1 low, 3 high never accepted
    for (int i = 0; i < 6; i++) cyc(2'b00, 2'd0, '0);
    begin
      logic [6:0] pat;
      pat = 7'b1110111;
      for (int i = 0; i < 15; i++) begin
        cyc((i < 7) ? {1'b0, pat[i]} : 2'b00, 2'd0, '0);
        chk("bounce_stable", 32'(stable[0]), 0);
        chk("bounce_pulses", 32'({pressPulse[0], releasePulse[0]}), 0);
      end
    end
    // Glitch of exactly D cycles is accepted, then its low period too
    pcnt = 0; rcnt = 0;
    for (int i = 0; i < 14; i++) begin
      cyc((i < 4) ? 2'b01 : 2'b00, 2'd0, '0);
      pcnt += int'(pressPulse[0]); rcnt += int'(releasePulse[0]);
      if (i == 5) chk("glitch_press_edge", 32'(pressPulse[0]), 1);
      if (i == 9) chk("glitch_release_edge", 32'(releasePulse[0]), 1);
    end
    chk("glitch_press_count", pcnt, 1);
    chk("glitch_release_count", rcnt, 1);

    // Toggle on channel 1: three presses read 1, 0, 1
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) cyc((i < 8) ? 2'b10 : 2'b00, 2'd2, '0);
      chk($sformatf("toggle%0d", p), 32'(switchOut[1]), (p % 2 == 0) ? 1 : 0);
    end
    // Fourth press with clear held across the press edge: clear wins
    for (int i = 0; i < 8; i++) begin
      cyc(2'b10, 2'd2, (i >= 3 && i <= 5) ? 2'b10 : 2'b00);
      if (i == 5) begin
        chk("clear_press_pulse", 32'(pressPulse[1]), 1);
        chk("clear_wins", 32'(switchOut[1]), 0);
      end
    end
    for (int i = 0; i < 8; i++) cyc(2'b00, 2'd2, '0);

    // Simultaneous rise on both channels
    for (int i = 0; i < 8; i++) begin
      cyc(2'b11, 2'd0, '0);
      if (i == 5) begin
        chk("simul_press", 32'(pressPulse), 32'h3);
        chk("simul_any", 32'(anyPress), 1);
      end
      if (i == 6) chk("simul_any_drop", 32'(anyPress), 0);
    end

    // Mode 3 with stable=01, then mode flipping during a channel-1 debounce
    for (int i = 0; i < 8; i++) cyc(2'b01, 2'd0, '0);
    cyc(2'b01, 2'd3, '0);
    chk("mode3_out", 32'(switchOut), 32'h2);
    cyc(2'b01, 2'd0, '0);
    chk("mode0_out", 32'(switchOut), 32'h1);
    for (int i = 0; i < 8; i++) begin
      cyc(2'b11, (i % 2 == 0) ? 2'd3 : 2'd0, '0);
      if (i == 4) chk("modeflip_hold", 32'(stable), 32'h1);
      if (i == 5) chk("modeflip_accept", 32'(stable), 32'h3);
    end

    // Random stimulus against the model
    rs = sw; rm = 2'd0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 5) == 0) rs[c] = ~rs[c];
      if ($urandom_range(0, 19) == 0) rm = 2'($urandom_range(0, 3));
      rc = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
      cyc(rs, rm, rc);
    end

    // Asynchronous reset two cycles into a debounce
    for (int i = 0; i < 8; i++) cyc(2'b00, 2'd3, '0);
    for (int i = 0; i < 4; i++) cyc(2'b11, 2'd3, '0);
    #2 isReset = 1'b1;
    #1;
    chk("arst_stable", 32'(stable), 0);
    chk("arst_pulses", 32'({pressPulse, releasePulse}), 0);
    chk("arst_out_mode3", 32'(switchOut), 32'h3);
    chk("arst_any", 32'(anyPress), 0);
    @(negedge clock);
    isReset = 1'b0; model_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(2'b11, 2'd0, '0);
      if (i == 4) chk("arst_still_low", 32'(stable), 0);
      if (i == 5) begin
        chk("arst_reaccept", 32'(stable), 32'h3);
        chk("arst_press", 32'(pressPulse), 32'h3);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
